timer_ctrl: RTL



---
 rtl/timer_ctrl.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
//
// Register-window controller that sequences an external countdown timer.
// Software programs PERIOD, then sets CTRL.en. The block pulses a load to
// the timer, waits one cycle for the timer to absorb the load, and watches
// the count for zero. Each expiry sets sticky status and bumps an event
// counter, and can raise a level interrupt. In periodic mode the block
// reloads the timer automatically; in one-shot mode it returns to idle.
//
// Register map (addr_i):
//   0 CTRL   [0] en, [1] periodic, [2] irq_en        (R/W)
//   1 PERIOD full width, sampled at every reload      (R/W)
//   2 STATUS [0] expired, [1] overrun, [3] err (W1C), [2] busy (RO),
//            [8 +: ECNT_W] expiry count (RO, wraps)
//   3 COUNT  tmr_cuenta_i passthrough                 (RO)
//
// Ports:
//   clk_10M      system clock
//   rst          synchronous active-low reset
//   we_i         register write strobe, one cycle per write
//   addr_i       register select
//   wdata_i      write data
//   rdata_o      read data for the previous cycle's addr_i (registered)
//   irq_o        level interrupt, expired & irq_en (registered)
//   tmr_data_o   load value to the timer (the PERIOD register)
//   tmr_load_o   one-cycle load pulse to the timer (registered)
//   tmr_cuenta_i current timer count; the timer holds at zero
// -----------------------------------------------------------------------------
module timer_ctrl #(
    parameter int CNT_W  = 32,
    parameter int ECNT_W = 8
) (
    input  logic              clk_10M,
    input  logic              rst,
    input  logic              we_i,
    input  logic [1:0]        addr_i,
    input  logic [CNT_W-1:0]  wdata_i,
    output logic [CNT_W-1:0]  rdata_o,
    output logic              irq_o,
    output logic [CNT_W-1:0]  tmr_data_o,
    output logic              tmr_load_o,
    input  logic [CNT_W-1:0]  tmr_cuenta_i
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ARM    = 3'd2,
        ST_RUN    = 3'd3,
        ST_EXPIRE = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_fsm_s;
    state_t              state_nxt_s;

    logic                en_r;
    logic                periodic_r;
    logic                irq_en_r;
    logic [CNT_W-1:0]    period_r;
    logic                expired_r;
    logic                overrun_r;
    logic                err_r;
    logic [ECNT_W-1:0]   ecnt_r;

    logic                en_nxt_s;
    logic                periodic_nxt_s;
    logic                irq_en_nxt_s;
    logic [CNT_W-1:0]    period_nxt_s;
    logic                expired_nxt_s;
    logic                overrun_nxt_s;
    logic                err_nxt_s;
    logic [ECNT_W-1:0]   ecnt_nxt_s;

    logic                ctrl_wr_s;
    logic                period_wr_s;
    logic                status_wr_s;
    logic                disable_s;
    logic                period_zero_s;
    logic                expire_s;
    logic                busy_s;
    logic                err_set_s;
    logic                en_clr_s;
    logic [CNT_W-1:0]    status_s;
    logic [CNT_W-1:0]    rdata_nxt_s;

    // The timer is always offered the programmed period; it only latches
    // it on a load pulse, so a mid-run PERIOD write lands at the next reload.
    assign tmr_data_o = period_r;

    // Write decode and frequently used state conditions.
    always_comb begin
        ctrl_wr_s     = we_i && (addr_i == 2'd0);
        period_wr_s   = we_i && (addr_i == 2'd1);
        status_wr_s   = we_i && (addr_i == 2'd2);
        disable_s     = ctrl_wr_s && !wdata_i[0];
        period_zero_s = (period_r == {CNT_W{1'b0}});
        expire_s      = (state_r == ST_EXPIRE);
        busy_s        = (state_r != ST_IDLE);
    end

    // Sequencer next state plus the err / en side effects of each transition.
    always_comb begin
        state_fsm_s = state_r;
        err_set_s   = 1'b0;
        en_clr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ctrl_wr_s && wdata_i[0]) begin
                    if (!period_zero_s) begin
                        state_fsm_s = ST_LOAD;
                    end else begin
                        // Refuse to start on a zero period: flag and drop en.
                        err_set_s = 1'b1;
                        en_clr_s  = 1'b1;
                    end
                end else begin
                    state_fsm_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_fsm_s = ST_ARM;
            end
            ST_ARM: begin
                // The count is stale during LOAD; one cycle later it is valid.
                state_fsm_s = ST_RUN;
            end
            ST_RUN: begin
                if (tmr_cuenta_i == {CNT_W{1'b0}}) begin
                    state_fsm_s = ST_EXPIRE;
                end else begin
                    state_fsm_s = ST_RUN;
                end
            end
            ST_EXPIRE: begin
                if (periodic_r) begin
                    if (!period_zero_s) begin
                        state_fsm_s = ST_LOAD;
                    end else begin
                        state_fsm_s = ST_IDLE;
                        err_set_s   = 1'b1;
                        en_clr_s    = 1'b1;
                    end
                end else begin
                    state_fsm_s = ST_IDLE;
                    en_clr_s    = 1'b1;
                end
            end
            default: begin
                state_fsm_s = ST_IDLE;
                en_clr_s    = 1'b1;
            end
        endcase
        // Software disable overrides every transition; status is untouched.
        if (disable_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            state_nxt_s = state_fsm_s;
        end
    end

    // Next values of the software-visible registers; hardware sets win over W1C.
    always_comb begin
        if (en_clr_s) begin
            en_nxt_s = 1'b0;
        end else if (ctrl_wr_s) begin
            en_nxt_s = wdata_i[0];
        end else begin
            en_nxt_s = en_r;
        end

        if (ctrl_wr_s) begin
            periodic_nxt_s = wdata_i[1];
            irq_en_nxt_s   = wdata_i[2];
        end else begin
            periodic_nxt_s = periodic_r;
            irq_en_nxt_s   = irq_en_r;
        end

        if (period_wr_s) begin
            period_nxt_s = wdata_i;
        end else begin
            period_nxt_s = period_r;
        end

        if (expire_s) begin
            expired_nxt_s = 1'b1;
        end else if (status_wr_s && wdata_i[0]) begin
            expired_nxt_s = 1'b0;
        end else begin
            expired_nxt_s = expired_r;
        end

        // Overrun looks at expired before any same-cycle clear.
        if (expire_s && expired_r) begin
            overrun_nxt_s = 1'b1;
        end else if (status_wr_s && wdata_i[1]) begin
            overrun_nxt_s = 1'b0;
        end else begin
            overrun_nxt_s = overrun_r;
        end

        if (err_set_s) begin
            err_nxt_s = 1'b1;
        end else if (status_wr_s && wdata_i[3]) begin
            err_nxt_s = 1'b0;
        end else begin
            err_nxt_s = err_r;
        end

        if (expire_s) begin
            ecnt_nxt_s = ecnt_r + {{(ECNT_W-1){1'b0}}, 1'b1};
        end else begin
            ecnt_nxt_s = ecnt_r;
        end
    end

    // Read multiplexer over the current register contents.
    always_comb begin
        status_s                = {CNT_W{1'b0}};
        status_s[0]             = expired_r;
        status_s[1]             = overrun_r;
        status_s[2]             = busy_s;
        status_s[3]             = err_r;
        status_s[8 +: ECNT_W]   = ecnt_r;
        rdata_nxt_s             = {CNT_W{1'b0}};
        case (addr_i)
            2'd0: begin
                rdata_nxt_s[2:0] = {irq_en_r, periodic_r, en_r};
            end
            2'd1: begin
                rdata_nxt_s = period_r;
            end
            2'd2: begin
                rdata_nxt_s = status_s;
            end
            2'd3: begin
                rdata_nxt_s = tmr_cuenta_i;
            end
            default: begin
                rdata_nxt_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, register file and registered outputs.
    always_ff @(posedge clk_10M) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            en_r       <= 1'b0;
            periodic_r <= 1'b0;
            irq_en_r   <= 1'b0;
            period_r   <= {CNT_W{1'b0}};
            expired_r  <= 1'b0;
            overrun_r  <= 1'b0;
            err_r      <= 1'b0;
            ecnt_r     <= {ECNT_W{1'b0}};
            rdata_o    <= {CNT_W{1'b0}};
            irq_o      <= 1'b0;
            tmr_load_o <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            en_r       <= en_nxt_s;
            periodic_r <= periodic_nxt_s;
            irq_en_r   <= irq_en_nxt_s;
            period_r   <= period_nxt_s;
            expired_r  <= expired_nxt_s;
            overrun_r  <= overrun_nxt_s;
            err_r      <= err_nxt_s;
            ecnt_r     <= ecnt_nxt_s;
            rdata_o    <= rdata_nxt_s;
            // Built from next values so irq and load line up with the state.
            irq_o      <= expired_nxt_s & irq_en_nxt_s;
            tmr_load_o <= (state_nxt_s == ST_LOAD);
        end
    end

endmodule
